// File: rtl/if_decode_skid_stage.sv
// IF->Decode pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional performance counters (stall_cnt, flush_cnt) enabled by macro IFD_PERF_CNT_EN.
module if_decode_skid_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
`ifdef IFD_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic              in_ready_q;
  logic              acc_in, acc_out;
  logic              load_main_in, load_main_skid, load_skid_in;

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc_in) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          load_main_in = 1'b1;
        end else if (acc_in) begin
          next_state   = TWO;
          load_skid_in = 1'b1;
        end else if (acc_out) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (acc_out) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush cancels every load so an emptied stage still shows the last head pc.
    if (flush) begin
      next_state     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_addr  <= '0;
      main_inst  <= NOP_INST;
      skid_addr  <= '0;
      skid_inst  <= NOP_INST;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != TWO);
      if (load_main_in) begin
        main_addr <= in_addr;
        main_inst <= in_inst;
      end else if (load_main_skid) begin
        main_addr <= skid_addr;
        main_inst <= skid_inst;
      end
      if (load_skid_in) begin
        skid_addr <= in_addr;
        skid_inst <= in_inst;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_addr  = main_addr;
  assign out_inst  = out_valid ? main_inst : NOP_INST;
  assign occupancy = state;

`ifdef IFD_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_decode_skid_stage.sv
// Self-checking bench for if_decode_skid_stage against a queue-based FIFO model.
// Build with IFD_PERF_CNT_EN defined to also check the performance counters.
module tb_if_decode_skid_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_inst;
  logic [1:0]  occupancy;
`ifdef IFD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  if_decode_skid_stage #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_inst(out_inst), .occupancy(occupancy)
`ifdef IFD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr = '0;
  int          m_stall = 0;
  int          m_flush = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    chk("out_valid", 64'(out_valid), 64'(n > 0));
    chk("in_ready", 64'(in_ready), 64'(n < 2));
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("out_addr", 64'(out_addr), 64'(m_addr));
    chk("out_inst", 64'(out_inst), 64'((n > 0) ? q[0].i : NOP));
`ifdef IFD_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // One clock: drive at negedge, update the model at the edge, check 1 time unit later.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] i,
                      input logic r, input logic f);
    logic acc_in, acc_out;
    @(negedge clock);
    in_valid = v; in_addr = a; in_inst = i; out_ready = r; flush = f;
    @(posedge clock);
    acc_in  = v && (q.size() < 2);
    acc_out = r && (q.size() > 0);
    if (q.size() > 0 && !r && m_stall < 65535) m_stall++;
    if (f && m_flush < 65535) m_flush++;
    if (f) q.delete();
    else begin
      if (acc_out) void'(q.pop_front());
      if (acc_in) q.push_back('{a: a, i: i});
    end
    if (q.size() > 0) m_addr = q[0].a;
    #1 check_all();
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    in_valid = 1'b0; flush = 1'b0; reset = 1'b1;
    #1;
    q.delete(); m_addr = '0; m_stall = 0; m_flush = 0;
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 check_all();
    @(negedge clock);
    reset = 1'b0;

    // streaming with decode always ready
    step(1, 32'h0, 32'h11110000, 1, 0);
    step(1, 32'h4, 32'h11110004, 1, 0);
    chk("stream_occ", 64'(occupancy), 64'd1);
    step(1, 32'h8, 32'h11110008, 1, 0);
    chk("stream_addr8", 64'(out_addr), 64'h8);
    step(0, 32'h0, 32'h0, 1, 0);

    // decode hold fills the skid buffer
    step(1, 32'h10, 32'hAAAA0001, 0, 0);
    step(1, 32'h14, 32'hAAAA0002, 0, 0);
    chk("two_occ", 64'(occupancy), 64'd2);
    chk("two_ready", 64'(in_ready), 64'd0);
    step(1, 32'h18, 32'hAAAA0003, 0, 0);
    chk("two_hold_addr", 64'(out_addr), 64'h10);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("pop1_addr", 64'(out_addr), 64'h14);
    chk("pop1_ready", 64'(in_ready), 64'd1);
    step(0, 32'h0, 32'h0, 1, 0);

    // flush in TWO with a concurrent push
    step(1, 32'h30, 32'hBBBB0001, 0, 0);
    step(1, 32'h34, 32'hBBBB0002, 0, 0);
    step(1, 32'h20, 32'hCCCC0020, 0, 1);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_inst", 64'(out_inst), 64'(NOP));
    step(0, 32'h0, 32'h0, 1, 0);
    chk("flush_no20", 64'(out_valid), 64'd0);

    // asynchronous reset while full
    step(1, 32'h40, 32'hDDDD0001, 0, 0);
    step(1, 32'h44, 32'hDDDD0002, 0, 0);
    mid_reset();
    step(1, 32'h50, 32'hEEEE0001, 0, 0);
    chk("post_reset_occ", 64'(occupancy), 64'd1);
    chk("post_reset_addr", 64'(out_addr), 64'h50);
    step(0, 32'h0, 32'h0, 1, 0);

    // randomized handshakes, no flush
    for (int k = 0; k < 1000; k++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    // randomized with occasional flush
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

`ifdef IFD_PERF_CNT_EN
    mid_reset();
    step(1, 32'h60, 32'h1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 32'h0, 32'h0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 32'h0, 32'h0, 1, 1);
    chk("stall_cnt5", 64'(stall_cnt), 64'd5);
    chk("flush_cnt3", 64'(flush_cnt), 64'd3);
    step(1, 32'h64, 32'h2, 0, 0);
    for (int k = 0; k < 70000; k++) step(0, 32'h0, 32'h0, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
